// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and step-counter sizing helper
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  // ceil(log2(n)), never below 1 so a single-step build still gets a 1-bit counter
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle
//   producer side: in_valid, in_ready, a, b, bin
//   consumer side: out_valid, out_ready, diff, bout, ovf
interface serial_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, ovf);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_sub_slice.sv
// sub_slice: combinational DIGIT-bit ripple-borrow subtractor slice
//   x, y : slice of minuend / subtrahend
//   bi   : borrow into the slice LSB
//   d    : x - y - bi (slice bits)
//   bo   : borrow out of the slice MSB
module sub_slice #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);
  logic [DIGIT:0] br;
  always_comb begin
    br = '0;
    d = '0;
    br[0] = bi;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ br[i];
      br[i+1] = (~x[i] & y[i]) | (br[i] & ~(x[i] ^ y[i]));
    end
    bo = br[DIGIT];
  end
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle A - B - BIN, DIGIT bits per clock through a registered borrow
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : slave side of serial_subtractor_if (operands in, diff/bout/ovf out)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave io
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int SW = clog2_min1(NSTEP);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic borrow_q, borrow_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [SW-1:0] step_q, step_d;
  logic [DIGIT-1:0] slice_x, slice_y, slice_d;
  logic slice_bo, accept, last;
  // in_ready is forced low while reset is asserted; DONE with out_ready allows a bubble-free accept
  assign io.in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & io.out_ready));
  assign accept = io.in_valid & io.in_ready;
  assign last = step_q == SW'(NSTEP - 1);
  assign slice_x = a_q[int'(step_q)*DIGIT +: DIGIT];
  assign slice_y = b_q[int'(step_q)*DIGIT +: DIGIT];
  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .x(slice_x), .y(slice_y), .bi(borrow_q), .d(slice_d), .bo(slice_bo)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    bout_d = bout_q;
    ovf_d = ovf_q;
    step_d = step_q;
    if (state_q == RUN) begin
      diff_d[int'(step_q)*DIGIT +: DIGIT] = slice_d;
      borrow_d = slice_bo;
      step_d = step_q + SW'(1);
      if (last) begin
        state_d = DONE;
        bout_d = slice_bo;
        ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
      end
    end
    if (state_q == DONE && io.out_ready) state_d = IDLE;
    if (accept) begin
      a_d = io.a;
      b_d = io.b;
      borrow_d = io.bin;
      step_d = '0;
      state_d = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      bout_q <= 1'b0;
      ovf_q <= 1'b0;
      step_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      bout_q <= bout_d;
      ovf_q <= ovf_d;
      step_q <= step_d;
    end
  end
  assign io.out_valid = state_q == DONE;
  assign io.diff = diff_q;
  assign io.bout = bout_q;
  assign io.ovf = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of the 4-step and 1-step subtractor builds
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int fails = 0;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(16)) bus ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
  serial_subtractor #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .io(bus16.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bin, input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(input string tag, input int lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
  endtask
  task automatic expect_res(input string tag, input logic [15:0] d, input logic bo, input logic ov);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(d));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(bo));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
  endtask
  task automatic consume;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] ra, rb, ed;
    logic rbin, eb, eo;
    logic [16:0] full;
    int seen;
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.bin = 0; bus.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.bin = 0; bus16.out_ready = 1;
    tick;
    tick;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_flags", {30'd0, bus.bout, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    issue(16'h0005, 16'h0003, 1'b0, "t1");
    wait_valid("t1", 4);
    expect_res("t1", 16'h0002, 1'b0, 1'b0);
    consume;
    issue(16'h0000, 16'h0001, 1'b0, "t2a");
    wait_valid("t2a", 4);
    expect_res("t2a", 16'hFFFF, 1'b1, 1'b0);
    consume;
    issue(16'h8000, 16'h0001, 1'b0, "t2b");
    wait_valid("t2b", 4);
    expect_res("t2b", 16'h7FFF, 1'b0, 1'b1);
    consume;
    issue(16'h0001, 16'h0000, 1'b1, "t3a");
    wait_valid("t3a", 4);
    expect_res("t3a", 16'h0000, 1'b0, 1'b0);
    consume;
    issue(16'h0000, 16'h0000, 1'b1, "t3b");
    wait_valid("t3b", 4);
    expect_res("t3b", 16'hFFFF, 1'b1, 1'b0);
    consume;
    issue(16'h00F0, 16'h000F, 1'b0, "t4");
    wait_valid("t4", 4);
    bus.a = 16'h1234;
    bus.b = 16'h0234;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
      expect_res("t4_hold", 16'h00E1, 1'b0, 1'b0);
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_b2b_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("t4_b2b_accepted", 32'(bus.out_valid), 32'd0);
    wait_valid("t4b", 4);
    expect_res("t4b", 16'h1000, 1'b0, 1'b0);
    consume;
    issue(16'h5555, 16'h1111, 1'b0, "t5");
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_diff", 32'(bus.diff), 32'd0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("t5_no_stale_result", 32'(seen), 32'd0);
    issue(16'h5555, 16'h1111, 1'b0, "t5r");
    wait_valid("t5r", 4);
    expect_res("t5r", 16'h4444, 1'b0, 1'b0);
    consume;
    for (int i = 0; i < 50; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
      ed = full[15:0];
      eb = full[16];
      eo = (ra[15] ^ rb[15]) & (ra[15] ^ ed[15]);
      issue(ra, rb, rbin, "rnd4");
      wait_valid("rnd4", 4);
      expect_res("rnd4", ed, eb, eo);
      consume;
    end
    bus16.a = 16'hFFFF;
    bus16.b = 16'hFFFF;
    bus16.bin = 1'b0;
    bus16.in_valid = 1'b1;
    chk("t6_in_ready", 32'(bus16.in_ready), 32'd1);
    tick;
    bus16.in_valid = 1'b0;
    chk("t6_not_yet", 32'(bus16.out_valid), 32'd0);
    tick;
    chk("t6_result", {13'd0, bus16.out_valid, bus16.bout, bus16.ovf, bus16.diff}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    tick;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
      ed = full[15:0];
      eb = full[16];
      eo = (ra[15] ^ rb[15]) & (ra[15] ^ ed[15]);
      bus16.a = ra;
      bus16.b = rb;
      bus16.bin = rbin;
      bus16.in_valid = 1'b1;
      tick;
      bus16.in_valid = 1'b0;
      tick;
      chk("rnd16", {13'd0, bus16.out_valid, bus16.bout, bus16.ovf, bus16.diff}, {13'd0, 1'b1, eb, eo, ed});
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
